// File: rtl/initialization_sequence_controller_pkg.sv
// Shared types and constants for the 8259A write-side command sequencer.
package initialization_sequence_controller_pkg;

  // Initialization progress; encodings 5..7 are illegal and recover to UNINIT.
  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } init_state_e;

  // Bit positions inside the written data byte.
  localparam int ICW1_D4_BIT   = 4;
  localparam int OCW3_D3_BIT   = 3;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW1_IC4_BIT  = 0;

  // One bit per registered pulse; at most one write strobe is ever set.
  typedef struct packed {
    logic icw1;
    logic icw2;
    logic icw3;
    logic icw4;
    logic icw4_default;
    logic ocw1;
    logic ocw2;
    logic ocw3;
    logic seq_error;
  } strobe_t;

  // True for the five defined state encodings.
  function automatic logic is_legal_state(input logic [2:0] s);
    return (s <= 3'd4);
  endfunction

endpackage

// File: rtl/initialization_sequence_controller.sv
// Classifies CPU writes as ICW1-4 / OCW1-3, steps the initialization
// sequence, and issues registered one-cycle strobes plus a data copy.
module initialization_sequence_controller #(
  parameter bit SEQ_ERROR_ENABLE = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       write_enable,
  input  logic       address_a0,
  input  logic [7:0] internal_data_bus,
  output logic [7:0] captured_data,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       icw4_default,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       initialization_done,
  output logic       sequence_error,
  output logic [2:0] init_state
);
  import initialization_sequence_controller_pkg::*;

  init_state_e state_q, state_d;
  logic        single_q, single_d;
  logic        ic4_q, ic4_d;
  strobe_t     strobe_q, strobe_d;
  logic [7:0]  data_q;
  logic        accept;

  logic is_icw1;
  assign is_icw1 = !address_a0 && internal_data_bus[ICW1_D4_BIT];

  // State and latched ICW1 configuration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= UNINIT;
      single_q <= 1'b0;
      ic4_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      single_q <= single_d;
      ic4_q    <= ic4_d;
    end
  end

  // Write decode and next-state selection.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d  = state_q;
    single_d = single_q;
    ic4_d    = ic4_q;
    strobe_d = '0;
    accept   = 1'b0;

    if (!is_legal_state(state_q)) begin
      state_d = UNINIT;
    end else if (write_enable) begin
      if (is_icw1) begin
        // ICW1 restarts the sequence from any state.
        strobe_d.icw1 = 1'b1;
        single_d      = internal_data_bus[ICW1_SNGL_BIT];
        ic4_d         = internal_data_bus[ICW1_IC4_BIT];
        state_d       = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: begin
            if (address_a0) begin
              strobe_d.icw2 = 1'b1;
              if (!single_q) begin
                state_d = WAIT_ICW3;
              end else if (ic4_q) begin
                state_d = WAIT_ICW4;
              end else begin
                state_d               = READY;
                strobe_d.icw4_default = 1'b1;
              end
            end else begin
              strobe_d.seq_error = SEQ_ERROR_ENABLE;
            end
          end
          WAIT_ICW3: begin
            if (address_a0) begin
              strobe_d.icw3 = 1'b1;
              if (ic4_q) begin
                state_d = WAIT_ICW4;
              end else begin
                state_d               = READY;
                strobe_d.icw4_default = 1'b1;
              end
            end else begin
              strobe_d.seq_error = SEQ_ERROR_ENABLE;
            end
          end
          WAIT_ICW4: begin
            if (address_a0) begin
              strobe_d.icw4 = 1'b1;
              state_d       = READY;
            end else begin
              strobe_d.seq_error = SEQ_ERROR_ENABLE;
            end
          end
          READY: begin
            if (address_a0) begin
              strobe_d.ocw1 = 1'b1;
            end else if (internal_data_bus[OCW3_D3_BIT]) begin
              strobe_d.ocw3 = 1'b1;
            end else begin
              strobe_d.ocw2 = 1'b1;
            end
          end
          default: begin
            // UNINIT: only ICW1 is meaningful before initialization.
            strobe_d.seq_error = SEQ_ERROR_ENABLE;
          end
        endcase
      end
      accept = (strobe_d.icw1 | strobe_d.icw2 | strobe_d.icw3 | strobe_d.icw4 |
                strobe_d.ocw1 | strobe_d.ocw2 | strobe_d.ocw3);
    end
  end

  // Registered strobes and data copy; reset cancels any pending pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= '0;
      data_q   <= 8'h00;
    end else begin
      strobe_q <= strobe_d;
      if (accept) begin
        data_q <= internal_data_bus;
      end
    end
  end

  // Output mapping from registered state and strobes.
  always_comb begin
    captured_data                  = data_q;
    write_initial_command_word_1   = strobe_q.icw1;
    write_initial_command_word_2   = strobe_q.icw2;
    write_initial_command_word_3   = strobe_q.icw3;
    write_initial_command_word_4   = strobe_q.icw4;
    icw4_default                   = strobe_q.icw4_default;
    write_operation_control_word_1 = strobe_q.ocw1;
    write_operation_control_word_2 = strobe_q.ocw2;
    write_operation_control_word_3 = strobe_q.ocw3;
    sequence_error                 = strobe_q.seq_error;
    initialization_done            = (state_q == READY);
    init_state                     = state_q;
  end

endmodule

// File: tb/tb_initialization_sequence_controller.sv
// Directed bench for the 8259A initialization sequence controller.
module tb_initialization_sequence_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_enable = 1'b0;
  logic       address_a0 = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic [7:0] captured_data;
  logic       icw1_s, icw2_s, icw3_s, icw4_s, def_s, ocw1_s, ocw2_s, ocw3_s;
  logic       initialization_done, sequence_error;
  logic [2:0] init_state;

  int errors = 0;
  int checks = 0;

  // Pulse vector: {icw1, icw2, icw3, icw4, icw4_default, ocw1, ocw2, ocw3, seq_error}
  localparam logic [8:0] P_NONE = 9'b0_0000_0000;
  localparam logic [8:0] P_ICW1 = 9'b1_0000_0000;
  localparam logic [8:0] P_ICW2 = 9'b0_1000_0000;
  localparam logic [8:0] P_ICW3 = 9'b0_0100_0000;
  localparam logic [8:0] P_ICW4 = 9'b0_0010_0000;
  localparam logic [8:0] P_DEF  = 9'b0_0001_0000;
  localparam logic [8:0] P_OCW1 = 9'b0_0000_1000;
  localparam logic [8:0] P_OCW2 = 9'b0_0000_0100;
  localparam logic [8:0] P_OCW3 = 9'b0_0000_0010;
  localparam logic [8:0] P_ERR  = 9'b0_0000_0001;

  logic [8:0] pulses;
  assign pulses = {icw1_s, icw2_s, icw3_s, icw4_s, def_s, ocw1_s, ocw2_s, ocw3_s,
                   sequence_error};

  initialization_sequence_controller dut (
    .clock                         (clock),
    .reset_n                       (reset_n),
    .write_enable                  (write_enable),
    .address_a0                    (address_a0),
    .internal_data_bus             (internal_data_bus),
    .captured_data                 (captured_data),
    .write_initial_command_word_1  (icw1_s),
    .write_initial_command_word_2  (icw2_s),
    .write_initial_command_word_3  (icw3_s),
    .write_initial_command_word_4  (icw4_s),
    .icw4_default                  (def_s),
    .write_operation_control_word_1(ocw1_s),
    .write_operation_control_word_2(ocw2_s),
    .write_operation_control_word_3(ocw3_s),
    .initialization_done           (initialization_done),
    .sequence_error                (sequence_error),
    .init_state                    (init_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write; returns #1 after the sampling edge with write_enable low again.
  task automatic do_write(input logic a0, input logic [7:0] data);
    @(negedge clock);
    write_enable      = 1'b1;
    address_a0        = a0;
    internal_data_bus = data;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
  endtask

  // Check pulses, state, done and captured data after a write.
  task automatic expect_all(input string tag, input logic [8:0] p, input logic [2:0] st,
                            input logic done, input logic [7:0] cap);
    check({tag, ".pulses"}, {23'd0, pulses}, {23'd0, p});
    check({tag, ".state"}, {29'd0, init_state}, {29'd0, st});
    check({tag, ".done"}, {31'd0, initialization_done}, {31'd0, done});
    check({tag, ".cap"}, {24'd0, captured_data}, {24'd0, cap});
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    apply_reset();
    #1;
    expect_all("reset", P_NONE, 3'd0, 1'b0, 8'h00);

    // 1: single, ICW4 needed
    do_write(1'b0, 8'h13); expect_all("t1.icw1", P_ICW1, 3'd1, 1'b0, 8'h13);
    do_write(1'b1, 8'h08); expect_all("t1.icw2", P_ICW2, 3'd3, 1'b0, 8'h08);
    do_write(1'b1, 8'h01); expect_all("t1.icw4", P_ICW4, 3'd4, 1'b1, 8'h01);
    @(posedge clock); #1;
    expect_all("t1.idle", P_NONE, 3'd4, 1'b1, 8'h01);

    // 2: cascade, no ICW4
    do_write(1'b0, 8'h10); expect_all("t2.icw1", P_ICW1, 3'd1, 1'b0, 8'h10);
    do_write(1'b1, 8'h20); expect_all("t2.icw2", P_ICW2, 3'd2, 1'b0, 8'h20);
    do_write(1'b1, 8'h04); expect_all("t2.icw3", P_ICW3 | P_DEF, 3'd4, 1'b1, 8'h04);

    // 3: operation control words in READY
    do_write(1'b1, 8'hFF); expect_all("t3.ocw1", P_OCW1, 3'd4, 1'b1, 8'hFF);
    do_write(1'b0, 8'h20); expect_all("t3.ocw2", P_OCW2, 3'd4, 1'b1, 8'h20);
    do_write(1'b0, 8'h0B); expect_all("t3.ocw3", P_OCW3, 3'd4, 1'b1, 8'h0B);

    // 4: restart from WAIT_ICW3 relatches configuration
    do_write(1'b0, 8'h10); do_write(1'b1, 8'h20);
    check("t4.pre_state", {29'd0, init_state}, 32'd2);
    do_write(1'b0, 8'h13); expect_all("t4.icw1", P_ICW1, 3'd1, 1'b0, 8'h13);
    do_write(1'b1, 8'h08); expect_all("t4.icw2", P_ICW2, 3'd3, 1'b0, 8'h08);

    // 5: illegal writes
    apply_reset();
    do_write(1'b1, 8'hAA); expect_all("t5.uninit_a0", P_ERR, 3'd0, 1'b0, 8'h00);
    do_write(1'b0, 8'h13); expect_all("t5.icw1", P_ICW1, 3'd1, 1'b0, 8'h13);
    do_write(1'b0, 8'h0A); expect_all("t5.wait2_err", P_ERR, 3'd1, 1'b0, 8'h13);

    // 6: back-to-back writes, then reset while a strobe is pending
    @(negedge clock);
    write_enable = 1'b1; address_a0 = 1'b0; internal_data_bus = 8'h11;
    @(posedge clock); #1;
    expect_all("t6.icw1", P_ICW1, 3'd1, 1'b0, 8'h11);
    address_a0 = 1'b1; internal_data_bus = 8'h22;
    @(posedge clock); #1;
    expect_all("t6.icw2", P_ICW2, 3'd2, 1'b0, 8'h22);
    write_enable = 1'b0;
    reset_n = 1'b0;
    #1;
    expect_all("t6.async_rst", P_NONE, 3'd0, 1'b0, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    expect_all("t6.post_rst", P_NONE, 3'd0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/initialization_sequence_controller.md
Name: initialization_sequence_controller

Overview:
Write-side command sequencer for the 8259A control logic. It classifies each CPU write as ICW1-ICW4 or OCW1-OCW3 using A0, D4 and D3 and the current initialization state. It steps the ICW1→ICW2→[ICW3]→[ICW4] sequence and issues one-cycle write strobes plus a registered data copy to the ICW/OCW register modules and the IMR.

Parameters:
SEQ_ERROR_ENABLE, 1, when 1 the sequence_error pulse is driven; when 0 it is tied low.

Ports:
clock  input  1  system clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
write_enable  input  1  one-cycle pulse from bus control: a CPU write has completed
address_a0  input  1  A0 sampled with the write
internal_data_bus  input  8  write data sampled with the write
captured_data  output  8  registered copy of internal_data_bus from the last accepted write
write_initial_command_word_1  output  1  one-cycle strobe
write_initial_command_word_2  output  1  one-cycle strobe
write_initial_command_word_3  output  1  one-cycle strobe
write_initial_command_word_4  output  1  one-cycle strobe
icw4_default  output  1  one-cycle strobe: ICW4 skipped (IC4=0), so ICW4 fields clear to 0
write_operation_control_word_1  output  1  one-cycle strobe
write_operation_control_word_2  output  1  one-cycle strobe
write_operation_control_word_3  output  1  one-cycle strobe
initialization_done  output  1  high in READY state
sequence_error  output  1  one-cycle pulse: write ignored as illegal for current state
init_state  output  3  current state encoding (debug/visibility)

Behaviour:
- States: UNINIT=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4. Other encodings go to UNINIT.
- Reset (async, reset_n=0):
  - state=UNINIT, captured_data=8'h00.
  - Internal single_cfg=0 and ic4_cfg=0.
  - All strobes, initialization_done and sequence_error =0.
- Write classes are evaluated only when write_enable=1:
  - ICW1 = A0=0 & D4=1, in any state including READY and mid-sequence. It latches single_cfg=D1 and ic4_cfg=D0, then goes to WAIT_ICW2.
  - WAIT_ICW2 + A0=1: ICW2. Next state is WAIT_ICW3 if single_cfg=0; else WAIT_ICW4 if ic4_cfg=1; else READY with icw4_default.
  - WAIT_ICW3 + A0=1: ICW3. Next state is WAIT_ICW4 if ic4_cfg=1; else READY with icw4_default.
  - WAIT_ICW4 + A0=1: ICW4, then READY.
  - READY + A0=1: OCW1.
  - READY + A0=0, D4=0, D3=0: OCW2.
  - READY + A0=0, D4=0, D3=1: OCW3.
  - UNINIT or WAIT_ICWx + A0=0, D4=0: ignored, state unchanged, sequence_error pulses.
  - UNINIT + A0=1: ignored, sequence_error pulses.
- Latency: every strobe, icw4_default and sequence_error are registered. Each is high for exactly the one cycle after the write_enable cycle.
- captured_data updates in that same edge, but only for accepted writes. Downstream modules latch captured_data while their strobe is high.
- The state transition occurs on the same edge as the strobe. initialization_done rises together with the last ICW strobe, or with icw4_default.
- At most one write strobe is high per cycle. icw4_default coincides with the ICW2 or ICW3 strobe that ends the sequence.
- An ICW1 mid-sequence or in READY restarts the sequence. initialization_done drops on the ICW1 strobe cycle.
- write_enable on consecutive cycles: each is processed in order, with no stall and no lost writes.
- Reset mid-sequence: immediate return to UNINIT. Any pending strobe is cancelled.

Decomposition:
- Shared package: state enum (UNINIT..READY, 3 bits) and bit-position constants.
  - ICW1_D4_BIT=4, OCW3_D3_BIT=3, ICW1_SNGL_BIT=1, ICW1_IC4_BIT=0.
- Single module with no sub-module. Structure: a combinational decode/next-state block plus one registered output block.

Test Plan:
1. Reset, then write (A0=0, 8'h13) → ICW1 strobe, captured_data=8'h13. Then (A0=1, 8'h08) → ICW2 strobe, icw4_default=0, state WAIT_ICW4. Then (A0=1, 8'h01) → ICW4 strobe, initialization_done=1.
2. Cascade, no ICW4: 8'h10, then A0=1 8'h20, then A0=1 8'h04 → ICW1, ICW2, ICW3 strobes. icw4_default and initialization_done rise together with the ICW3 strobe.
3. READY: (A0=1, 8'hFF) → OCW1. (A0=0, 8'h20) → OCW2. (A0=0, 8'h0B) → OCW3. No sequence_error.
4. Restart: in WAIT_ICW3, write (A0=0, 8'h13) → ICW1 strobe, state WAIT_ICW2, configuration relatched (single_cfg=1, ic4_cfg=1).
5. Illegal writes: after reset (A0=1, 8'hAA) → sequence_error, no strobe, captured_data stays 8'h00. In WAIT_ICW2, (A0=0, 8'h0A) → sequence_error, state unchanged.
6. Back-to-back write_enable for ICW1/ICW2 on adjacent cycles → strobes on adjacent cycles. Then assert reset_n=0 mid-sequence → all outputs 0 asynchronously, state UNINIT.
